alarm_zone_ctrl: RTL and testbench
==================================

// Module: alarm_zone_ctrl
// PURPOSE
//  Parametrised, clocked successor of the combinational keypad/sensor alarm mux. Arms and
//  disarms from keypad codes, monitors N sensor zones, and runs exit/entry delay timers.
//  Latches which zones tripped and holds the siren for a bounded time.
//  Sits between the keypad decoder/sensor synchronisers and the siren/status-LED drivers.
// PARAMETERS
//  N_ZONES      3         number of sensor zones (>=1)
//  KEY_W        5         keypad code width
//  ARM_CODE     5'b00001  code that arms the system
//  DISARM_CODE  5'b00100  code that disarms / silences
//  DELAY_ZONES  'b001     bit i=1: zone i is a delayed (entry) zone; else instant
//  EXIT_CYC     16        exit-delay length in clk cycles (>=1)
//  ENTRY_CYC    16        entry-delay length in clk cycles (>=1)
//  SIREN_CYC    64        siren hold time in clk cycles (>=1)
//  CNT_W        $clog2(max(EXIT_CYC,ENTRY_CYC,SIREN_CYC)+1)  timer width, derived
// PORTS
//  clk          in   1        single clock, all logic rising-edge
//  rst          in   1        synchronous, active-high reset
//  key          in   KEY_W    keypad code, sampled only when key_vld=1
//  key_vld      in   1        one-cycle strobe: key holds a new code
//  zone         in   N_ZONES  sensor inputs, pre-synchronised, 1 = tripped
//  zone_bypass  in   N_ZONES  1 = ignore that zone while armed
//  active       out  1        1 in ARMED, ENTRY, ALARM
//  pending      out  1        1 in EXIT or ENTRY (delay running)
//  alarm        out  1        siren drive, 1 only in ALARM
//  tripped      out  N_ZONES  sticky record of zones that caused entry/alarm
//  bad_key      out  1        one-cycle pulse: key_vld with unrecognised code
// BEHAVIOUR
//  Reset: state=DISARMED, timer=0, active=pending=alarm=0, tripped=0, bad_key=0.
//  All outputs registered; decisions take effect on the clk edge after the input is seen.
//  Effective trip vector t = zone & ~zone_bypass; t_inst = t & ~DELAY_ZONES; t_dly = t & DELAY_ZONES.
//  States (shared enum): DISARMED, EXIT, ARMED, ENTRY, ALARM.
//   DISARMED: ARM_CODE -> EXIT, timer=EXIT_CYC-1, tripped cleared. Zones ignored.
//   EXIT: timer decrements each cycle; at timer==0 -> ARMED. Zones ignored.
//   ARMED: t_inst!=0 -> ALARM, timer=SIREN_CYC-1.
//    Otherwise t_dly!=0 -> ENTRY, timer=ENTRY_CYC-1.
//    tripped |= t on the transition cycle.
//   ENTRY: timer decrements; timer==0 -> ALARM (timer=SIREN_CYC-1).
//    t_inst!=0 -> ALARM immediately. tripped |= t every cycle.
//   ALARM: timer decrements; timer==0 -> ARMED (auto re-arm, tripped kept).
//    tripped |= t every cycle.
//  DISARM_CODE (key_vld=1) in any state except DISARMED -> DISARMED, timer=0.
//   Takes priority over all zone events and timer expiry in the same cycle. tripped held.
//  ARM_CODE outside DISARMED: ignored, no bad_key.
//  DISARM_CODE in DISARMED: ignored, no bad_key.
//  Any other code with key_vld=1: bad_key=1 for the next cycle, state unchanged.
//  key is don't-care when key_vld=0.
//  Timer saturates at 0 and never wraps.
//  rst mid-delay or mid-alarm: full reset next edge; no residual pulse on alarm.
//  Exit delay of length EXIT_CYC: active rises exactly EXIT_CYC cycles after the ARM strobe edge.
// STRUCTURE
//  Package alarm_pkg: state enum alarm_state_t, default ARM/DISARM code localparams.
//  Sub-module alarm_delay_timer: loadable CNT_W down-counter with load/value/zero outputs.
//   One instance, shared by the EXIT, ENTRY and ALARM states.
//  Top: FSM, trip masking, tripped register, key decode.
// TESTING
//  ARM (key=00001) -> pending=1 for 16 cycles, then active=1, pending=0, alarm=0.
//  Armed; zone[1] (instant) pulses 1 cycle -> alarm=1 next edge, tripped=3'b010.
//   alarm holds 64 cycles, then returns to ARMED.
//  Armed; zone[0] (delayed) -> pending=1; DISARM at cycle 10 -> all of active/pending/alarm=0.
//   alarm never rises; tripped=3'b001.
//  Armed; zone[0] with no key -> alarm=1 exactly 16 cycles after ENTRY entered.
//  zone_bypass=3'b010, armed; zone[1]=1 -> no state change.
//   key=5'b11111 with key_vld -> bad_key pulse, state unchanged.
//  Same cycle: DISARM strobe + zone[2] trip + timer expiry in ENTRY -> DISARMED.
//   rst asserted mid-ALARM -> all outputs 0 next edge.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm zone controller.
//   alarm_state_t : controller state encoding
//   *_DEF         : default keypad codes
//   max3()        : helper for sizing the shared delay timer
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } alarm_state_t;

    localparam int unsigned KEY_W_DEF       = 5;
    localparam logic [4:0]  ARM_CODE_DEF    = 5'b00001;
    localparam logic [4:0]  DISARM_CODE_DEF = 5'b00100;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/alarm_delay_timer.sv
// Loadable saturating down-counter shared by the exit, entry and siren delays.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val this cycle (wins over decrement)
//   load_val  : value to load
//   value     : registered count, decrements by one each cycle until zero
//   zero_c    : value == 0 (combinational decode of the register)
module alarm_delay_timer #(
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             zero_c
);

    assign zero_c = (value == '0);

    // Count down and hold at zero; never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (!zero_c) begin
            value <= value - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alarm_zone_ctrl.sv
// Keypad-armed N-zone alarm controller with exit/entry delays and bounded siren.
//   clk, rst     : clock, synchronous active-high reset
//   key, key_vld : keypad code and its one-cycle strobe
//   zone         : synchronised sensor inputs, 1 = tripped
//   zone_bypass  : 1 = ignore that zone
//   active       : armed, entry delay or alarm
//   pending      : exit or entry delay running
//   alarm        : siren drive
//   tripped      : sticky record of zones that caused entry/alarm
//   bad_key      : one-cycle pulse for an unrecognised code
module alarm_zone_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned         N_ZONES     = 3,
    parameter int unsigned         KEY_W       = KEY_W_DEF,
    parameter logic [KEY_W-1:0]    ARM_CODE    = KEY_W'(ARM_CODE_DEF),
    parameter logic [KEY_W-1:0]    DISARM_CODE = KEY_W'(DISARM_CODE_DEF),
    parameter logic [N_ZONES-1:0]  DELAY_ZONES = N_ZONES'(1),
    parameter int unsigned         EXIT_CYC    = 16,
    parameter int unsigned         ENTRY_CYC   = 16,
    parameter int unsigned         SIREN_CYC   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_W-1:0]   key,
    input  logic               key_vld,
    input  logic [N_ZONES-1:0] zone,
    input  logic [N_ZONES-1:0] zone_bypass,
    output logic               active,
    output logic               pending,
    output logic               alarm,
    output logic [N_ZONES-1:0] tripped,
    output logic               bad_key
);

    localparam int unsigned TIMER_MAX = max3(EXIT_CYC, ENTRY_CYC, SIREN_CYC);
    localparam int unsigned CNT_W     = $clog2(TIMER_MAX + 1);

    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYC - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYC - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYC - 1);

    alarm_state_t       state;
    alarm_state_t       state_nxt;
    logic [N_ZONES-1:0] tripped_nxt;
    logic               bad_key_nxt;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_load_val;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_zero_c;

    logic [N_ZONES-1:0] t_all_c;
    logic [N_ZONES-1:0] t_inst_c;
    logic [N_ZONES-1:0] t_dly_c;
    logic               arm_c;
    logic               disarm_c;

    // Trip masking: bypassed zones never count, then split instant vs delayed.
    assign t_all_c  = zone & ~zone_bypass;
    assign t_inst_c = t_all_c & ~DELAY_ZONES;
    assign t_dly_c  = t_all_c & DELAY_ZONES;

    // Key decode: each code only acts in the states where it means something.
    assign arm_c    = key_vld && (key == ARM_CODE) && (state == ST_DISARMED);
    assign disarm_c = key_vld && (key == DISARM_CODE) && (state != ST_DISARMED);

    alarm_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .value    (tmr_val),
        .zero_c   (tmr_zero_c)
    );

    // Next-state, timer load and tripped-record decode.
    always_comb begin
        state_nxt    = state;
        tripped_nxt  = tripped;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        bad_key_nxt  = key_vld && (key != ARM_CODE) && (key != DISARM_CODE);

        if (disarm_c) begin
            // Disarm beats zone events and timer expiry; tripped is preserved.
            state_nxt    = ST_DISARMED;
            tmr_load     = 1'b1;
            tmr_load_val = '0;
        end else begin
            unique case (state)
                ST_DISARMED: begin
                    if (arm_c) begin
                        state_nxt    = ST_EXIT;
                        tmr_load     = 1'b1;
                        tmr_load_val = EXIT_LOAD;
                        tripped_nxt  = '0;
                    end
                end
                ST_EXIT: begin
                    if (tmr_zero_c) begin
                        state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (t_inst_c != '0) begin
                        state_nxt    = ST_ALARM;
                        tmr_load     = 1'b1;
                        tmr_load_val = SIREN_LOAD;
                        tripped_nxt  = tripped | t_all_c;
                    end else if (t_dly_c != '0) begin
                        state_nxt    = ST_ENTRY;
                        tmr_load     = 1'b1;
                        tmr_load_val = ENTRY_LOAD;
                        tripped_nxt  = tripped | t_all_c;
                    end
                end
                ST_ENTRY: begin
                    tripped_nxt = tripped | t_all_c;
                    if ((t_inst_c != '0) || tmr_zero_c) begin
                        state_nxt    = ST_ALARM;
                        tmr_load     = 1'b1;
                        tmr_load_val = SIREN_LOAD;
                    end
                end
                ST_ALARM: begin
                    tripped_nxt = tripped | t_all_c;
                    if (tmr_zero_c) begin
                        state_nxt = ST_ARMED;
                    end
                end
                default: begin
                    state_nxt    = ST_DISARMED;
                    tmr_load     = 1'b1;
                    tmr_load_val = '0;
                end
            endcase
        end
    end

    // State register; status outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_DISARMED;
            active  <= 1'b0;
            pending <= 1'b0;
            alarm   <= 1'b0;
            tripped <= '0;
            bad_key <= 1'b0;
        end else begin
            state   <= state_nxt;
            active  <= (state_nxt == ST_ARMED) || (state_nxt == ST_ENTRY) ||
                       (state_nxt == ST_ALARM);
            pending <= (state_nxt == ST_EXIT) || (state_nxt == ST_ENTRY);
            alarm   <= (state_nxt == ST_ALARM);
            tripped <= tripped_nxt;
            bad_key <= bad_key_nxt;
        end
    end

    // The shared timer is only ever loaded with one of the three delay lengths.
    always_comb begin
        assert (tmr_val <= CNT_W'(TIMER_MAX));
    end

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Directed bench for alarm_zone_ctrl with default parameters.
module tb_alarm_zone_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] key;
    logic       key_vld;
    logic [2:0] zone;
    logic [2:0] zone_bypass;
    logic       active;
    logic       pending;
    logic       alarm;
    logic [2:0] tripped;
    logic       bad_key;
    logic [2:0] st;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [4:0] ARM    = 5'b00001;
    localparam logic [4:0] DISARM = 5'b00100;
    localparam logic [2:0] S_OFF  = 3'b000;  // {active, pending, alarm}
    localparam logic [2:0] S_DLY  = 3'b010;
    localparam logic [2:0] S_ARM  = 3'b100;
    localparam logic [2:0] S_ENT  = 3'b110;
    localparam logic [2:0] S_ALM  = 3'b101;

    alarm_zone_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .key_vld     (key_vld),
        .zone        (zone),
        .zone_bypass (zone_bypass),
        .active      (active),
        .pending     (pending),
        .alarm       (alarm),
        .tripped     (tripped),
        .bad_key     (bad_key)
    );

    always #5 clk = ~clk;

    assign st = {active, pending, alarm};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] code);
        key     = code;
        key_vld = 1'b1;
        tick();
        key_vld = 1'b0;
        key     = 5'b10101;
    endtask

    // Arm and sit out the full exit delay.
    task automatic arm_up();
        press(ARM);
        check("arm_exit_start", 32'(st), 32'(S_DLY));
        repeat (15) tick();
        check("arm_exit_last", 32'(st), 32'(S_DLY));
        tick();
        check("arm_armed", 32'(st), 32'(S_ARM));
    endtask

    initial begin
        rst = 1'b1; key = '0; key_vld = 1'b0; zone = '0; zone_bypass = '0;
        tick(); tick();
        check("rst_status", 32'(st), 32'(S_OFF));
        check("rst_tripped", 32'(tripped), 32'd0);
        check("rst_bad_key", 32'(bad_key), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_status", 32'(st), 32'(S_OFF));

        // Arm, then instant zone 1 -> siren for 64 cycles -> auto re-arm.
        arm_up();
        zone = 3'b010; tick(); zone = '0;
        check("inst_alarm", 32'(st), 32'(S_ALM));
        check("inst_tripped", 32'(tripped), 32'b010);
        repeat (63) tick();
        check("siren_hold", 32'(st), 32'(S_ALM));
        tick();
        check("siren_rearm", 32'(st), 32'(S_ARM));
        check("rearm_tripped", 32'(tripped), 32'b010);

        press(DISARM);
        check("disarm_status", 32'(st), 32'(S_OFF));
        check("disarm_tripped", 32'(tripped), 32'b010);

        // Delayed zone 0, disarm on the 10th entry cycle.
        press(ARM);
        check("arm_clears_trip", 32'(tripped), 32'd0);
        repeat (16) tick();
        check("armed_again", 32'(st), 32'(S_ARM));
        zone = 3'b001; tick(); zone = '0;
        check("entry_start", 32'(st), 32'(S_ENT));
        check("entry_tripped", 32'(tripped), 32'b001);
        repeat (9) tick();
        check("entry_mid", 32'(st), 32'(S_ENT));
        press(DISARM);
        check("entry_disarm", 32'(st), 32'(S_OFF));
        check("entry_disarm_trip", 32'(tripped), 32'b001);

        // Entry delay expiring into alarm, then reset mid-alarm.
        arm_up();
        zone = 3'b001; tick(); zone = '0;
        check("entry2_start", 32'(st), 32'(S_ENT));
        repeat (15) tick();
        check("entry2_last", 32'(st), 32'(S_ENT));
        tick();
        check("entry2_alarm", 32'(st), 32'(S_ALM));
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_alarm", 32'(st), 32'(S_OFF));
        check("rst_mid_tripped", 32'(tripped), 32'd0);
        tick();
        check("after_rst", 32'(st), 32'(S_OFF));

        // Bypassed zone is ignored; bad and redundant codes.
        arm_up();
        zone_bypass = 3'b010; zone = 3'b010;
        tick();
        check("bypass_1", 32'(st), 32'(S_ARM));
        tick();
        check("bypass_2", 32'(st), 32'(S_ARM));
        check("bypass_trip", 32'(tripped), 32'd0);
        zone = '0; zone_bypass = '0;
        press(5'b11111);
        check("bad_key_pulse", 32'(bad_key), 32'd1);
        check("bad_key_state", 32'(st), 32'(S_ARM));
        tick();
        check("bad_key_drop", 32'(bad_key), 32'd0);
        press(ARM);
        check("arm_when_armed_bk", 32'(bad_key), 32'd0);
        check("arm_when_armed_st", 32'(st), 32'(S_ARM));

        // Disarm, instant trip and entry expiry all in one cycle.
        zone = 3'b001; tick(); zone = '0;
        check("entry3_start", 32'(st), 32'(S_ENT));
        repeat (15) tick();
        check("entry3_last", 32'(st), 32'(S_ENT));
        zone = 3'b100; key = DISARM; key_vld = 1'b1;
        tick();
        key_vld = 1'b0; zone = '0;
        check("prio_disarm", 32'(st), 32'(S_OFF));
        check("prio_tripped", 32'(tripped), 32'b001);

        // Codes while disarmed.
        press(5'b11111);
        check("bad_key_off", 32'(bad_key), 32'd1);
        check("bad_key_off_st", 32'(st), 32'(S_OFF));
        press(DISARM);
        check("disarm_off_bk", 32'(bad_key), 32'd0);
        check("disarm_off_st", 32'(st), 32'(S_OFF));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
